// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: sequences core reset, runs the core and ends the run on halt, stop or cycle budget
module mips_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 100,
  parameter int STALL_LIMIT  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop_req,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_count
);
  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam int SC_W = $clog2(STALL_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic             core_reset_q, core_reset_d, running_q, running_d, done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [PC_W-1:0]  halt_pc_q, halt_pc_d, prev_pc_q, prev_pc_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [SC_W-1:0]  same_cnt_q, same_cnt_d;
  logic             first, eq, stall, tmo;
  // next state, counters and registered outputs; cycle_count==0 in RUN marks the first RUN cycle
  always_comb begin
    state_d       = state_q;
    timeout_d     = timeout_q;
    halt_pc_d     = halt_pc_q;
    prev_pc_d     = prev_pc_q;
    cycle_count_d = cycle_count_q;
    rst_cnt_d     = rst_cnt_q;
    same_cnt_d    = same_cnt_q;
    first         = cycle_count_q == '0;
    eq            = pc == prev_pc_q;
    stall         = !first && eq && (same_cnt_q + SC_W'(1) == SC_W'(STALL_LIMIT));
    tmo           = cycle_count_q + CNT_W'(1) == CNT_W'(MAX_CYCLES);
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d       = RST;
        cycle_count_d = '0;
        timeout_d     = 1'b0;
        halt_pc_d     = '0;
        rst_cnt_d     = '0;
      end
      RST: begin
        rst_cnt_d = rst_cnt_q + RC_W'(1);
        state_d   = (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) ? RUN : RST;
      end
      RUN: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        prev_pc_d     = pc;
        same_cnt_d    = (!first && eq) ? same_cnt_q + SC_W'(1) : '0;
        if (stop_req || stall || tmo) begin
          state_d   = DONE;
          timeout_d = !stop_req && !stall;
          halt_pc_d = pc;
        end
      end
      default: state_d = IDLE;
    endcase
    core_reset_d = state_d != RUN;
    running_d    = state_d == RUN;
    done_d       = state_d == DONE;
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      core_reset_q  <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      halt_pc_q     <= '0;
      prev_pc_q     <= '0;
      cycle_count_q <= '0;
      rst_cnt_q     <= '0;
      same_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      core_reset_q  <= core_reset_d;
      running_q     <= running_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      halt_pc_q     <= halt_pc_d;
      prev_pc_q     <= prev_pc_d;
      cycle_count_q <= cycle_count_d;
      rst_cnt_q     <= rst_cnt_d;
      same_cnt_q    <= same_cnt_d;
    end
  end
  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign halt_pc     = halt_pc_q;
  assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: scoreboard bench for the run controller at default parameters
module tb_mips_run_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, stop_req;
  logic [31:0] pc;
  logic        core_reset, running, done, timeout;
  logic [31:0] halt_pc;
  logic [15:0] cycle_count;
  typedef struct packed {logic to; logic [15:0] cnt; logic [31:0] hpc;} exp_t;
  exp_t sb[$];
  exp_t e;
  int tests = 0, fails = 0;

  mips_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop_req(stop_req), .pc(pc),
    .core_reset(core_reset), .running(running), .done(done), .timeout(timeout),
    .halt_pc(halt_pc), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] pc_of(input int mode, input int k);
    case (mode)
      0: pc_of = (k <= 4) ? 32'((k - 1) * 4) : 32'h0C;
      1: pc_of = 32'((k - 1) * 4);
      default: pc_of = (k <= 6) ? 32'((k - 1) * 4) : 32'h14;
    endcase
  endfunction

  // drives pc each RUN cycle from the negedge after running rises until done, or reset at cycle rst_at
  task automatic drive_run(input int mode, input int stop_at, input int rst_at);
    int k = 1;
    while (1) begin
      pc = pc_of(mode, k);
      stop_req = (k == stop_at);
      reset = (k == rst_at);
      @(negedge clk);
      stop_req = 1'b0;
      if (reset) begin
        reset = 1'b0;
        return;
      end
      if (done) return;
      if (k >= 300) begin
        tests++; fails++;
        $display("FAIL run_bound: done=%b after %0d cycles, required 1", done, k);
        return;
      end
      k++;
    end
  endtask

  task automatic begin_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !running; i++) @(negedge clk);
    tests++;
    if (running !== 1'b1) begin
      fails++;
      $display("FAIL start_bound: running=%b, required 1", running);
    end
  endtask

  task automatic pop_check(input string name);
    e = sb.pop_front();
    tests++;
    if ({done, core_reset, running, timeout, cycle_count, halt_pc} !== {3'b110, e.to, e.cnt, e.hpc}) begin
      fails++;
      $display("FAIL %s: got done=%b core_reset=%b running=%b timeout=%b cnt=%0d halt_pc=%h, required 1 1 0 %b %0d %h",
               name, done, core_reset, running, timeout, cycle_count, halt_pc, e.to, e.cnt, e.hpc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop_req = 1'b0; pc = '0;
    repeat (2) @(negedge clk);
    tests++;
    if ({core_reset, running, done, timeout} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b, required 1000", {core_reset, running, done, timeout});
    end
    tests++;
    if (halt_pc !== 32'h0) begin fails++; $display("FAIL reset_halt_pc: got %h, required 0", halt_pc); end
    tests++;
    if (cycle_count !== 16'h0) begin fails++; $display("FAIL reset_cnt: got %0d, required 0", cycle_count); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_startup_halt();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tests++;
      if ({core_reset, running} !== ((i < 3) ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL startup_edge%0d: core_reset,running=%b, required %b", i, {core_reset, running}, (i < 3) ? 2'b10 : 2'b01);
      end
      if (i < 3) @(negedge clk);
    end
    sb.push_back('{to: 1'b0, cnt: 16'd8, hpc: 32'h0C});
    drive_run(0, 0, 0);
    pop_check("halt_run");
  endtask

  task automatic test_timeout();
    begin_run();
    sb.push_back('{to: 1'b1, cnt: 16'd100, hpc: 32'd396});
    drive_run(1, 0, 0);
    pop_check("timeout_run");
  endtask

  task automatic test_restart_stop();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({done, core_reset, timeout, cycle_count, halt_pc} !== {3'b010, 16'h0, 32'h0}) begin
      fails++;
      $display("FAIL restart_clear: done=%b core_reset=%b timeout=%b cnt=%0d halt_pc=%h, required 0 1 0 0 0",
               done, core_reset, timeout, cycle_count, halt_pc);
    end
    start = 1'b1; stop_req = 1'b1;
    @(negedge clk);
    start = 1'b0; stop_req = 1'b0;
    tests++;
    if ({core_reset, running, done} !== 3'b100) begin
      fails++;
      $display("FAIL rst_hold: core_reset,running,done=%b, required 100", {core_reset, running, done});
    end
    @(negedge clk);
    tests++;
    if ({core_reset, running} !== 2'b01) begin
      fails++;
      $display("FAIL rst_exit: core_reset,running=%b, required 01", {core_reset, running});
    end
    sb.push_back('{to: 1'b0, cnt: 16'd10, hpc: 32'h14});
    drive_run(2, 10, 0);
    pop_check("stop_over_stall");
  endtask

  task automatic test_midrun_reset();
    begin_run();
    drive_run(1, 0, 5);
    tests++;
    if ({core_reset, running, done, cycle_count, halt_pc} !== {3'b100, 16'h0, 32'h0}) begin
      fails++;
      $display("FAIL midrun_reset: core_reset=%b running=%b done=%b cnt=%0d halt_pc=%h, required 1 0 0 0 0",
               core_reset, running, done, cycle_count, halt_pc);
    end
  endtask

  task automatic test_back_to_back();
    begin_run();
    sb.push_back('{to: 1'b0, cnt: 16'd8, hpc: 32'h0C});
    drive_run(0, 0, 0);
    pop_check("after_reset_run");
    begin_run();
    sb.push_back('{to: 1'b0, cnt: 16'd3, hpc: 32'h08});
    drive_run(1, 3, 0);
    pop_check("stop_run");
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop_req = 1'b0; pc = '0;
    @(negedge clk);
    test_reset();
    test_startup_halt();
    test_timeout();
    test_restart_stop();
    test_midrun_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Parametrised run controller for the MIPS core: sequences the core reset, runs the core, and ends the run on PC self-loop (halt), an external stop or a cycle budget. It replaces fixed-delay reset and fixed-length runs with a reusable synthesizable block. It sits between the top-level clk/reset and the core's reset input, and observes the core PC.

Parameters:
PC_W, 32, PC width in bits
CNT_W, 16, cycle counter width
RESET_CYCLES, 2, cycles core_reset is held in RST state (>=1)
MAX_CYCLES, 100, RUN-cycle budget before timeout (1..2^CNT_W-1)
STALL_LIMIT, 4, consecutive equal-PC comparisons that signal halt (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high block reset
start  input  1  level, begin a run (sampled in IDLE/DONE only)
stop_req  input  1  level, end the current run (sampled in RUN only)
pc  input  PC_W  core program counter
core_reset  output  1  reset to the MIPS core, active-high
running  output  1  high in RUN state
done  output  1  high in DONE state
timeout  output  1  run ended by cycle budget (valid while done)
halt_pc  output  PC_W  PC captured when the run ended
cycle_count  output  CNT_W  number of RUN cycles in current/last run

Behaviour:
- All outputs are registered. One clock; reset is synchronous and active-high, with priority over all other inputs in any state, including mid-run.
- Reset values: state=IDLE, core_reset=1, running=0, done=0, timeout=0, halt_pc=0, cycle_count=0, internal rst_cnt=0, same_cnt=0, prev_pc=0.
- States: IDLE, RST, RUN, DONE.
- IDLE: core_reset=1. start=1 -> RST. On that edge: clear cycle_count, timeout, halt_pc and rst_cnt.
- RST: core_reset=1. rst_cnt increments each cycle. After exactly RESET_CYCLES cycles in RST -> RUN. start ignored.
- RUN: core_reset=0 and running=1 from the first RUN cycle. cycle_count increments by 1 every RUN cycle, including the exit cycle.
  - First RUN cycle: prev_pc<=pc, same_cnt<=0.
  - Later cycles: if pc==prev_pc then same_cnt+1, else same_cnt=0. prev_pc<=pc.
- RUN exit conditions are evaluated on the current cycle's inputs and counters. Priority is stop_req > stall > timeout.
  - stop_req=1: -> DONE, timeout=0.
  - stall (pc==prev_pc and same_cnt+1==STALL_LIMIT, not evaluated in the first RUN cycle): -> DONE, timeout=0.
  - timeout (cycle_count+1==MAX_CYCLES, i.e. this is the MAX_CYCLES-th RUN cycle): -> DONE, timeout=1.
  - On any exit edge: halt_pc<=pc.
- DONE: core_reset=1, running=0, done=1. timeout, halt_pc and cycle_count are held. start=1 -> RST, and done falls on that edge. stop_req is ignored.
- start ignored in RST/RUN. stop_req ignored outside RUN.
- cycle_count never wraps, because MAX_CYCLES<2^CNT_W bounds it. At timeout exit, cycle_count==MAX_CYCLES.
- Latency from start to core_reset falling: RESET_CYCLES+1 edges. Exit is visible (done=1) on the edge after the terminating condition is sampled.

Test Plan:
1. Reset then start pulse at cycle 0 (defaults) -> core_reset high for edges 1-2 (RST), low from edge 3; running=1 from edge 3.
2. RUN with pc sequence 0x00,0x04,0x08,0x0C then constant 0x0C -> done after 4 equal comparisons: halt_pc=0x0C, timeout=0, cycle_count=8, core_reset=1.
3. pc incrementing by 4 every cycle, no stop -> done with timeout=1 and cycle_count=100 exactly; halt_pc=pc of the 100th RUN cycle.
4. stop_req=1 on the 10th RUN cycle, same cycle as a stall hit -> DONE with timeout=0, cycle_count=10, halt_pc=current pc (stop_req wins).
5. reset asserted on the 5th RUN cycle -> next edge: IDLE, core_reset=1, running=0, cycle_count=0, halt_pc=0. start then runs normally from RST.
6. In DONE, pulse start -> done falls, cycle_count/timeout/halt_pc cleared, RST held 2 cycles, new run begins. start or stop_req pulsed during RST -> no effect.
